// File: rtl/ot_tx_word_arbiter.sv
// Packet-granular round-robin arbiter: two 32-bit word producers share one
// byte-wide valid/ready UART TX stream, each word sent least-significant byte first.
module ot_tx_word_arbiter #(
  parameter int unsigned INIT_PRIORITY = 0,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_word,
  input  logic        req0_last,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_word,
  input  logic        req1_last,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        owner,
  output logic        pkt_done,
  output logic        pkt_abort
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  localparam logic             INIT_RR   = (INIT_PRIORITY != 0);
  localparam logic             STALL_EN  = (STALL_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_abort_q, pkt_abort_d;

  logic        own_valid;
  logic [31:0] own_word;
  logic        own_last;
  logic        grant_sel;

  assign own_valid = owner_q ? req1_valid : req0_valid;
  assign own_word  = owner_q ? req1_word  : req0_word;
  assign own_last  = owner_q ? req1_last  : req0_last;

  // Under contention the pointer decides; otherwise whichever one is asking.
  assign grant_sel = (req0_valid && req1_valid) ? rr_q : req1_valid;

  assign req0_ready = (state_q == ST_ACCEPT) && !owner_q;
  assign req1_ready = (state_q == ST_ACCEPT) &&  owner_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    rr_d        = rr_q;
    stall_cnt_d = stall_cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    last_d      = last_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    pkt_done_d  = 1'b0;
    pkt_abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d     = grant_sel;
          busy_d      = 1'b1;
          stall_cnt_d = '0;
          state_d     = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        if (own_valid) begin
          word_d      = own_word;
          last_d      = own_last;
          stall_cnt_d = '0;
          idx_d       = 2'd0;
          tx_valid_d  = 1'b1;
          tx_data_d   = own_word[7:0];
          state_d     = ST_SEND;
        end else if (STALL_EN) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
          if (stall_cnt_d == STALL_LIM) begin
            pkt_abort_d = 1'b1;
            busy_d      = 1'b0;
            rr_d        = ~owner_q;
            stall_cnt_d = '0;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q != 2'd3) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = 8'(word_q >> {idx_d, 3'b000});
          end else begin
            tx_valid_d = 1'b0;
            if (last_q) begin
              pkt_done_d = 1'b1;
              busy_d     = 1'b0;
              rr_d       = ~owner_q;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_ACCEPT;
            end
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      rr_q        <= INIT_RR;
      stall_cnt_q <= '0;
      idx_q       <= 2'd0;
      word_q      <= 32'd0;
      last_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      stall_cnt_q <= stall_cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      last_q      <= last_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      pkt_done_q  <= pkt_done_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_abort = pkt_abort_q;

endmodule

// File: tb/tb_ot_tx_word_arbiter.sv
// Directed bench for ot_tx_word_arbiter: single word, multi-word packet,
// contention, backpressure, stall abort and asynchronous reset mid-packet.
module tb_ot_tx_word_arbiter;

  typedef struct packed { logic [31:0] word; logic lst; } wrd_t;
  typedef struct packed { int cyc; logic own; logic [7:0] data; } byt_t;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req0_ready, req0_last;
  logic [31:0] req0_word;
  logic        req1_valid, req1_ready, req1_last;
  logic [31:0] req1_word;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        busy, owner, pkt_done, pkt_abort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  int stab_err = 0;
  int stall_seen = 0;
  logic abort_busy = 1'b0;
  logic hs0 = 1'b0;
  logic hs1 = 1'b0;
  logic stall_prev = 1'b0;
  logic bp_en = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [3:0] bp_pat = 4'b1001;

  wrd_t q0[$];
  wrd_t q1[$];
  byt_t bq[$];

  logic [7:0] e_t1 [4]  = '{8'h79, 8'h0F, 8'hA5, 8'h07};
  logic [7:0] e_t2 [16] = '{8'h79, 8'h0F, 8'hA5, 8'h07, 8'h11, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] e_t3 [16] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hCC, 8'hBB, 8'hAA, 8'h99,
                            8'h88, 8'h77, 8'h66, 8'h55, 8'h00, 8'hFF, 8'hEE, 8'hDD};
  logic [15:0] e_t3o    = 16'hF0F0;
  logic [7:0] e_t4 [8]  = '{8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
  logic [7:0] e_t5 [8]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0] e_t5o     = 8'hF0;
  logic [7:0] e_t6 [12] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                            8'hEE, 8'hFF, 8'hC0, 8'h00};
  logic [11:0] e_t6o    = 12'hFF0;

  ot_tx_word_arbiter #(
    .INIT_PRIORITY(0),
    .STALL_TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_word(req0_word),
    .req0_last(req0_last),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_word(req1_word),
    .req1_last(req1_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .busy(busy),
    .owner(owner),
    .pkt_done(pkt_done),
    .pkt_abort(pkt_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Observe on the falling edge: a byte is recorded when it will be taken at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_valid && tx_ready) bq.push_back(byt_t'{cyc, owner, tx_data});
        if (stall_prev && !(tx_valid && tx_data == stall_data)) stab_err++;
        if (tx_valid && !tx_ready) stall_seen++;
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (pkt_done) done_cnt++;
        if (pkt_abort) begin
          abort_cnt++;
          abort_cyc  = cyc;
          abort_busy = busy;
        end
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
      end else begin
        stall_prev = 1'b0;
        hs0 = 1'b0;
        hs1 = 1'b0;
      end
    end
  end

  // Producers present the head of their queue and pop it after a handshake.
  initial begin
    req0_valid = 1'b0; req0_word = 32'd0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_word = 32'd0; req1_last = 1'b0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      hs0 = 1'b0;
      hs1 = 1'b0;
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_word = q0[0].word; req0_last = q0[0].lst;
      end else begin
        req0_valid = 1'b0;
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_word = q1[0].word; req1_last = q1[0].lst;
      end else begin
        req1_valid = 1'b0;
      end
      tx_ready = bp_en ? bp_pat[cyc % 4] : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int kind);
    if (kind == 0) return done_cnt;
    if (kind == 1) return bq.size();
    return abort_cnt;
  endfunction

  task automatic wait_for(input int kind, input int target, input int max_cyc, input string tag);
    int n = 0;
    while (cnt_of(kind) < target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(cnt_of(kind) >= target), 32'd1);
  endtask

  task automatic check_byte(input int idx, input logic [7:0] ed, input logic eo, input string tag);
    if (idx < bq.size()) begin
      chk($sformatf("%s_data[%0d]", tag, idx), 32'(bq[idx].data), 32'(ed));
      chk($sformatf("%s_owner[%0d]", tag, idx), 32'(bq[idx].own), 32'(eo));
    end else begin
      chk($sformatf("%s_count", tag), 32'(bq.size()), 32'(idx + 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b;
    int d0;
    int a0;
    int t0;

    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_abort", 32'(pkt_abort), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // 1: single word on req0
    step();
    d0 = done_cnt; b = bq.size(); t0 = cyc;
    q0.push_back(wrd_t'{32'h07A50F79, 1'b1});
    wait_for(0, d0 + 1, 40, "t1_done_timeout");
    for (int i = 0; i < 4; i++) check_byte(b + i, e_t1[i], 1'b0, "t1");
    chk("t1_latency", 32'(bq[b].cyc - t0), 32'd2);
    chk("t1_back_to_back", 32'(bq[b + 3].cyc - bq[b].cyc), 32'd3);
    repeat (3) @(negedge clk);
    chk("t1_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("t1_owner", 32'(owner), 32'd0);

    // 2: four-word packet on req1
    step();
    d0 = done_cnt; b = bq.size();
    q1.push_back(wrd_t'{32'h07A50F79, 1'b0});
    q1.push_back(wrd_t'{32'h00000011, 1'b0});
    q1.push_back(wrd_t'{32'h00000000, 1'b0});
    q1.push_back(wrd_t'{32'h00000001, 1'b1});
    wait_for(0, d0 + 1, 150, "t2_done_timeout");
    for (int i = 0; i < 16; i++) check_byte(b + i, e_t2[i], 1'b1, "t2");
    chk("t2_span", 32'(bq[b + 15].cyc - bq[b].cyc), 32'd18);
    repeat (3) @(negedge clk);
    chk("t2_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("t2_owner", 32'(owner), 32'd1);

    // 3: contention, alternating grants starting at req0
    step();
    d0 = done_cnt; b = bq.size();
    q0.push_back(wrd_t'{32'h11223344, 1'b1});
    q0.push_back(wrd_t'{32'h55667788, 1'b1});
    q1.push_back(wrd_t'{32'h99AABBCC, 1'b1});
    q1.push_back(wrd_t'{32'hDDEEFF00, 1'b1});
    wait_for(0, d0 + 4, 200, "t3_done_timeout");
    for (int i = 0; i < 16; i++) check_byte(b + i, e_t3[i], e_t3o[i], "t3");

    // 4: tx_ready backpressure 1,0,0,1
    step();
    d0 = done_cnt; b = bq.size();
    bp_en = 1'b1;
    q0.push_back(wrd_t'{32'hCAFEBABE, 1'b0});
    q0.push_back(wrd_t'{32'h0BADF00D, 1'b1});
    wait_for(0, d0 + 1, 200, "t4_done_timeout");
    for (int i = 0; i < 8; i++) check_byte(b + i, e_t4[i], 1'b0, "t4");
    chk("t4_byte_count", 32'(bq.size() - b), 32'd8);
    chk("t4_held_stable", 32'(stab_err), 32'd0);
    chk("t4_stalls_seen", 32'(stall_seen > 0), 32'd1);
    step();
    bp_en = 1'b0;

    // 5: owner stalls mid-packet, abort, pending req1 served next
    step();
    d0 = done_cnt; a0 = abort_cnt; b = bq.size();
    q0.push_back(wrd_t'{32'h12345678, 1'b0});
    wait_for(1, b + 1, 40, "t5_first_byte_timeout");
    step();
    q1.push_back(wrd_t'{32'hA1B2C3D4, 1'b1});
    wait_for(2, a0 + 1, 60, "t5_abort_timeout");
    chk("t5_abort_delay", 32'(abort_cyc - bq[b + 3].cyc), 32'd9);
    chk("t5_abort_busy", 32'(abort_busy), 32'd0);
    wait_for(0, d0 + 1, 60, "t5_done_timeout");
    for (int i = 0; i < 8; i++) check_byte(b + i, e_t5[i], e_t5o[i], "t5");
    chk("t5_regrant_delay", 32'(bq[b + 4].cyc - abort_cyc), 32'd2);
    chk("t5_abort_once", 32'(abort_cnt), 32'(a0 + 1));
    chk("t5_done_once", 32'(done_cnt), 32'(d0 + 1));

    // 6: async reset mid-SEND, then INIT_PRIORITY honoured again
    step();
    d0 = done_cnt;
    q0.push_back(wrd_t'{32'h0A0B0C0D, 1'b1});
    wait_for(0, d0 + 1, 40, "t6_pre_done_timeout");
    step();
    b = bq.size();
    q1.push_back(wrd_t'{32'h55AA33CC, 1'b1});
    wait_for(1, b + 2, 40, "t6_two_bytes_timeout");
    step();
    chk("t6_busy_before_reset", 32'(busy), 32'd1);
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_owner", 32'(owner), 32'd0);
    chk("t6_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_no_bytes_after_release", 32'(bq.size()), 32'(b + 2));
    chk("t6_idle_tx_valid", 32'(tx_valid), 32'd0);
    step();
    d0 = done_cnt; b = bq.size();
    q0.push_back(wrd_t'{32'h01020304, 1'b1});
    q1.push_back(wrd_t'{32'hDEADBEEF, 1'b0});
    q1.push_back(wrd_t'{32'h00C0FFEE, 1'b1});
    wait_for(0, d0 + 2, 100, "t6_done_timeout");
    for (int i = 0; i < 12; i++) check_byte(b + i, e_t6[i], e_t6o[i], "t6");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
